// File: rtl/divu_seq_unit.sv
// Multi-cycle radix-2 restoring unsigned divider feeding HiLo: dataOut = {remainder, quotient}.
// Optional signed DIV support is compiled in with `define DIVU_SEQ_SIGNED_EN.
module divu_seq_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [5:0] DIVU_CODE = 6'b011011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [5:0]         Signal,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] dataOut
);
    localparam int CNT_W = $clog2(WIDTH);

    // state | meaning
    // IDLE  | waiting for a qualified start
    // CALC  | one quotient bit per clock, busy high
    // DONE  | single cycle, done high, dataOut freshly written
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_nxt, quo_nxt, res_rem, res_quo;
    logic [WIDTH-1:0] op_a, op_b;
    logic             code_ok, accept;

`ifdef DIVU_SEQ_SIGNED_EN
    localparam logic [5:0] DIV_CODE = 6'b011010;
    logic is_div, neg_quo, neg_rem;

    assign is_div  = (Signal == DIV_CODE);
    assign code_ok = (Signal == DIVU_CODE) || is_div;
    assign op_a    = (is_div && dataA[WIDTH-1]) ? -dataA : dataA;
    assign op_b    = (is_div && dataB[WIDTH-1]) ? -dataB : dataB;
    // Sign fix folds into the final write so latency matches DIVU.
    assign res_quo = neg_quo ? -quo_nxt : quo_nxt;
    assign res_rem = neg_rem ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            neg_quo <= is_div && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            neg_rem <= is_div && dataA[WIDTH-1];
        end
    end
`else
    assign code_ok = (Signal == DIVU_CODE);
    assign op_a    = dataA;
    assign op_b    = dataB;
    assign res_quo = quo_nxt;
    assign res_rem = rem_nxt;
`endif

    assign accept = start && code_ok && (state != CALC);
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

    // rem < divisor always, so the shifted value fits WIDTH+1 bits and trial[WIDTH] is the sign.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, dvs};
    assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            div_by_zero <= 1'b0;
            dataOut     <= '0;
        end else if (accept) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= op_a;
            dvs         <= op_b;
            div_by_zero <= 1'b0;
            if (op_b == '0) begin
                state       <= DONE;
                div_by_zero <= 1'b1;
                dataOut     <= {dataA, {WIDTH{1'b1}}};
            end else begin
                state <= CALC;
            end
        end else begin
            case (state)
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        dataOut <= {res_rem, res_quo};
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
